ascii_bits_to_hex: RTL and testbench

//  Receive side of the ASCII bit-string format: parses a stream of ASCII '0'/'1' characters,
//  MSB first (e.g. from UART RX), into 4-bit nibbles and packs them into N_NIBBLES-wide words.

---
 rtl/ascii_bits_to_hex_if.sv | 31 +++
 rtl/ascii_bits_to_hex.sv | 135 +++++++++++++
 tb/tb_ascii_bits_to_hex.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/ascii_bits_to_hex_if.sv
// Bundles the character-input and nibble/word-output handshakes of
// ascii_bits_to_hex.
//   master : character source / output consumer side (drives char_in, char_valid, out_ready)
//   slave  : the parser (drives char_ready, nibble_out, word_out, word_last,
//            out_valid, err_char, err_partial)
interface ascii_bits_to_hex_if #(
  parameter int N_NIBBLES = 4
) ();
  logic [7:0]             char_in;
  logic                   char_valid;
  logic                   char_ready;
  logic [3:0]             nibble_out;
  logic [4*N_NIBBLES-1:0] word_out;
  logic                   word_last;
  logic                   out_valid;
  logic                   out_ready;
  logic                   err_char;
  logic                   err_partial;

  modport master (
    output char_in, char_valid, out_ready,
    input  char_ready, nibble_out, word_out, word_last, out_valid,
           err_char, err_partial
  );

  modport slave (
    input  char_in, char_valid, out_ready,
    output char_ready, nibble_out, word_out, word_last, out_valid,
           err_char, err_partial
  );
endinterface

// File: rtl/ascii_bits_to_hex.sv
// Parses a stream of ASCII '0'/'1' characters (MSB first) into 4-bit nibbles
// and packs N_NIBBLES nibbles into a word, first nibble in the MS position.
// Ports:
//   clk    : system clock, rising edge
//   reset  : asynchronous, active-high; clears all state
//   bus    : ascii_bits_to_hex_if.slave
//            char_in/char_valid/char_ready  : character input handshake
//            nibble_out/word_last/word_out  : completed nibble, word-end flag, packed word
//            out_valid/out_ready            : output handshake
//            err_char / err_partial         : 1-cycle error pulses
module ascii_bits_to_hex #(
  parameter int N_NIBBLES = 4
) (
  input  logic               clk,
  input  logic               reset,
  ascii_bits_to_hex_if.slave bus
);

  localparam int WORD_W = 4 * N_NIBBLES;
  localparam int CNT_W  = (N_NIBBLES > 1) ? $clog2(N_NIBBLES) : 1;

  typedef enum logic [1:0] {
    CH_DIGIT,
    CH_SEP,
    CH_EOL,
    CH_BAD
  } char_class_t;

  typedef enum logic {
    COLLECT,
    HOLD
  } state_t;

  function automatic char_class_t classify(input logic [7:0] c);
    case (c)
      8'h30, 8'h31: classify = CH_DIGIT;
      8'h20, 8'h5F: classify = CH_SEP;
      8'h0D, 8'h0A: classify = CH_EOL;
      default:      classify = CH_BAD;
    endcase
  endfunction

  state_t              state;
  logic [2:0]          shreg;     // the three most recent bits; the 4th arrives with char_in
  logic [1:0]          bit_cnt;
  logic [CNT_W-1:0]    nib_cnt;
  logic [WORD_W-1:0]   acc;

  char_class_t         cls;
  logic                accept;
  logic                pop;
  logic                complete;
  logic                word_done;
  logic [3:0]          nib_next;
  logic [WORD_W-1:0]   acc_next;

  // A held output blocks new characters unless it is being taken this cycle.
  assign bus.char_ready = (state == COLLECT) | bus.out_ready;

  always_comb begin
    cls       = classify(bus.char_in);
    accept    = bus.char_valid & bus.char_ready;
    pop       = (state == HOLD) & bus.out_ready;
    nib_next  = {shreg, bus.char_in[0]};
    complete  = accept && (cls == CH_DIGIT) && (bit_cnt == 2'd3);
    word_done = (nib_cnt == CNT_W'(N_NIBBLES - 1));
  end

  if (N_NIBBLES > 1) begin : g_multi
    assign acc_next = {acc[WORD_W-5:0], nib_next};
  end else begin : g_single
    assign acc_next = nib_next;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state           <= COLLECT;
      shreg           <= '0;
      bit_cnt         <= '0;
      nib_cnt         <= '0;
      acc             <= '0;
      bus.out_valid   <= 1'b0;
      bus.word_last   <= 1'b0;
      bus.nibble_out  <= '0;
      bus.word_out    <= '0;
      bus.err_char    <= 1'b0;
      bus.err_partial <= 1'b0;
    end else begin
      bus.err_char    <= 1'b0;
      bus.err_partial <= 1'b0;

      if (accept) begin
        unique case (cls)
          CH_DIGIT: begin
            shreg   <= nib_next[2:0];
            bit_cnt <= bit_cnt + 2'd1;   // wraps to 0 on the 4th digit
          end
          CH_EOL: begin
            bus.err_partial <= (bit_cnt != 2'd0) || (nib_cnt != '0);
            bit_cnt         <= '0;
            nib_cnt         <= '0;
            acc             <= '0;
          end
          CH_BAD: begin
            bus.err_char <= 1'b1;
            bit_cnt      <= '0;          // partial nibble dropped, word progress kept
          end
          default: ;                     // separators are consumed silently
        endcase
      end

      // A new nibble takes priority over a pop so back-to-back nibbles stay in HOLD.
      if (complete) begin
        state          <= HOLD;
        bus.out_valid  <= 1'b1;
        bus.nibble_out <= nib_next;
        if (word_done) begin
          bus.word_out  <= acc_next;
          bus.word_last <= 1'b1;
          acc           <= '0;
          nib_cnt       <= '0;
        end else begin
          bus.word_last <= 1'b0;
          acc           <= acc_next;
          nib_cnt       <= nib_cnt + CNT_W'(1);
        end
      end else if (pop) begin
        state         <= COLLECT;
        bus.out_valid <= 1'b0;
        bus.word_last <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_ascii_bits_to_hex.sv
// Directed bench for ascii_bits_to_hex: expected nibbles are queued as the
// stimulus is issued and a monitor compares them on every output transfer.
module tb_ascii_bits_to_hex;
  localparam int N = 4;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  ascii_bits_to_hex_if #(.N_NIBBLES(N)) bus ();
  ascii_bits_to_hex #(.N_NIBBLES(N)) dut (.clk(clk), .reset(reset), .bus(bus));

  typedef struct packed {
    logic [3:0]  nib;
    logic        last;
    logic [15:0] word;
  } exp_t;

  exp_t sbq[$];
  int total  = 0;
  int passed = 0;
  int errc_cnt = 0;
  int errp_cnt = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
  endtask

  task automatic exp_push(input logic [3:0] nib, input logic last, input logic [15:0] word);
    exp_t e;
    e.nib  = nib;
    e.last = last;
    e.word = word;
    sbq.push_back(e);
  endtask

  // Monitor: samples 1 time unit after the falling edge, away from the active edge.
  always @(negedge clk) begin
    exp_t e;
    #1;
    if (bus.err_char)    errc_cnt++;
    if (bus.err_partial) errp_cnt++;
    if (!reset && bus.out_valid && bus.out_ready) begin
      if (sbq.size() == 0) begin
        check("unexpected_output", 32'(bus.nibble_out), 32'hDEAD);
      end else begin
        e = sbq.pop_front();
        check("nibble_out", 32'(bus.nibble_out), 32'(e.nib));
        check("word_last",  32'(bus.word_last),  32'(e.last));
        check("word_out",   32'(bus.word_out),   32'(e.word));
      end
    end
  end

  // Called at a falling edge; returns at the falling edge after acceptance.
  task automatic send(input byte c);
    int n;
    n = 0;
    bus.char_in    = c;
    bus.char_valid = 1'b1;
    #1;
    while (!bus.char_ready && n < 50) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (n >= 50) check("char_ready_timeout", 32'(n), 32'd0);
    @(negedge clk);
    bus.char_valid = 1'b0;
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send(s[i]);
  endtask

  task automatic do_reset();
    bus.char_valid = 1'b0;
    reset = 1'b1;
    #1;
    check("rst_out_valid",   32'(bus.out_valid),   32'd0);
    check("rst_word_last",   32'(bus.word_last),   32'd0);
    check("rst_nibble_out",  32'(bus.nibble_out),  32'd0);
    check("rst_word_out",    32'(bus.word_out),    32'd0);
    check("rst_err_char",    32'(bus.err_char),    32'd0);
    check("rst_err_partial", 32'(bus.err_partial), 32'd0);
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    bus.char_in    = 8'h00;
    bus.char_valid = 1'b0;
    bus.out_ready  = 1'b1;
    @(negedge clk);
    do_reset();

    // 1: "0101" -> 5, valid one cycle after the 4th char
    exp_push(4'h5, 1'b0, 16'h0000);
    send_str("010");
    check("t1_no_early_valid", 32'(bus.out_valid), 32'd0);
    send("1");
    check("t1_valid_latency", 32'(bus.out_valid), 32'd1);
    @(negedge clk);
    check("t1_valid_dropped", 32'(bus.out_valid), 32'd0);

    // 2: full word with separators, then a second word
    do_reset();
    exp_push(4'h1, 1'b0, 16'h0000);
    exp_push(4'h2, 1'b0, 16'h0000);
    exp_push(4'h3, 1'b0, 16'h0000);
    exp_push(4'h4, 1'b1, 16'h1234);
    send_str("0001_0010 0011 0100");
    exp_push(4'hF, 1'b0, 16'h1234);
    exp_push(4'h0, 1'b0, 16'h1234);
    exp_push(4'hA, 1'b0, 16'h1234);
    exp_push(4'h5, 1'b1, 16'hF0A5);
    send_str("1111 0000 1010 0101");
    @(negedge clk);

    // 3: illegal char drops the partial nibble
    do_reset();
    send_str("01");
    send("x");
    check("t3_err_char_pulse", 32'(bus.err_char), 32'd1);
    exp_push(4'hF, 1'b0, 16'h0000);
    send("1");
    check("t3_err_char_cleared", 32'(bus.err_char), 32'd0);
    send_str("111");
    @(negedge clk);

    // 4: backpressure holds the output
    do_reset();
    bus.out_ready = 1'b0;
    exp_push(4'hA, 1'b0, 16'h0000);
    send_str("1010");
    for (int i = 0; i < 5; i++) begin
      #1;
      check("t4_char_ready_low", 32'(bus.char_ready), 32'd0);
      check("t4_nibble_stable",  32'(bus.nibble_out), 32'hA);
      check("t4_valid_held",     32'(bus.out_valid),  32'd1);
      @(negedge clk);
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    check("t4_popped", 32'(bus.out_valid), 32'd0);

    // 5: reset mid-stream discards partial bits
    do_reset();
    send_str("011");
    do_reset();
    exp_push(4'h8, 1'b0, 16'h0000);
    send_str("1000");
    @(negedge clk);

    // 6: line ends with partial and empty state
    do_reset();
    send_str("10");
    send(8'h0D);
    check("t6_err_partial_bits", 32'(bus.err_partial), 32'd1);
    send(8'h0D);
    check("t6_no_err_empty", 32'(bus.err_partial), 32'd0);
    exp_push(4'hC, 1'b0, 16'h0000);
    exp_push(4'h3, 1'b0, 16'h0000);
    send_str("1100 0011");
    send(8'h0A);
    check("t6_err_partial_word", 32'(bus.err_partial), 32'd1);
    // Word accumulator and nibble count were cleared by the LF
    exp_push(4'h1, 1'b0, 16'h0000);
    exp_push(4'h2, 1'b0, 16'h0000);
    exp_push(4'h3, 1'b0, 16'h0000);
    exp_push(4'h4, 1'b1, 16'h1234);
    send_str("0001001000110100");
    @(negedge clk);

    for (int i = 0; i < 20; i++) begin
      if (sbq.size() == 0) break;
      @(negedge clk);
    end
    @(negedge clk);
    check("sb_drain",        32'(sbq.size()), 32'd0);
    check("err_char_count",  32'(errc_cnt),   32'd1);
    check("err_partial_cnt", 32'(errp_cnt),   32'd2);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
